// File: rtl/bin16_to_bcd_seq.sv
// bin16_to_bcd_seq: sequential double-dabble binary-to-BCD converter with sign
// and leading-zero blanking outputs for a numeric display driver.
// Latency: out_valid rises WIDTH edges after the accepting edge; one word per WIDTH+2 cycles.
// Backpressure: result held in DONE until out_ready; in_ready is low outside IDLE.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    input handshake, in_data = WIDTH-bit word
//   out_valid/out_ready  output handshake
//   bcd                  packed BCD, digit 0 (units) in bits [3:0]
//   digit_en             per-digit display enable (leading-zero blanking)
//   neg                  input was negative (only when SIGNED_IN=1)
module bin16_to_bcd_seq #(
  parameter int WIDTH     = 16,
  parameter int DIGITS    = 5,
  parameter int SIGNED_IN = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  neg
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CONVERT = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [WIDTH-1:0]  shift_reg;
  logic [BW-1:0]     bcd_acc;
  logic [CW-1:0]     cnt;
  logic              sign_flag;

  logic [BW-1:0]     acc_adj;
  logic [BW-1:0]     acc_nxt;
  logic [WIDTH-1:0]  shift_nxt;
  logic [DIGITS-1:0] en_nxt;
  logic              any_nz;
  logic              last_step;
  logic              in_neg;
  logic [WIDTH-1:0]  magnitude;

  // Two's complement magnitude in WIDTH unsigned bits: the most negative
  // value maps to 2^(WIDTH-1), which still fits.
  always_comb begin
    in_neg    = (SIGNED_IN != 0) && in_data[WIDTH-1];
    magnitude = in_neg ? (~in_data + {{(WIDTH-1){1'b0}}, 1'b1}) : in_data;
  end

  // One double-dabble step: add 3 to every digit >= 5, then shift the
  // combined {bcd_acc, shift_reg} left by one bit.
  always_comb begin
    acc_adj = bcd_acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_acc[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = bcd_acc[4*i +: 4] + 4'd3;
      end
    end
    acc_nxt   = {acc_adj[BW-2:0], shift_reg[WIDTH-1]};
    shift_nxt = {shift_reg[WIDTH-2:0], 1'b0};
  end

  // Blanking: a digit is shown if it or any more significant digit is
  // nonzero; the units digit is always shown so zero displays as "0".
  always_comb begin
    any_nz = 1'b0;
    en_nxt = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      any_nz    = any_nz | (acc_nxt[4*i +: 4] != 4'd0);
      en_nxt[i] = any_nz;
    end
    en_nxt[0] = 1'b1;
  end

  assign last_step = (cnt == CW'(WIDTH - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = CONVERT;
      CONVERT: if (last_step) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // in_ready/out_valid are registered copies of the next state so both
  // read low while reset is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      bcd_acc   <= '0;
      cnt       <= '0;
      sign_flag <= 1'b0;
      bcd       <= '0;
      digit_en  <= '0;
      neg       <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shift_reg <= magnitude;
            sign_flag <= in_neg;
            bcd_acc   <= '0;
            cnt       <= '0;
          end
        end
        CONVERT: begin
          bcd_acc   <= acc_nxt;
          shift_reg <= shift_nxt;
          cnt       <= cnt + 1'b1;
          if (last_step) begin
            bcd      <= acc_nxt;
            digit_en <= en_nxt;
            neg      <= sign_flag;
          end
        end
        default: ;
      endcase
      state     <= state_nxt;
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_bin16_to_bcd_seq.sv
// Directed bench for bin16_to_bcd_seq: an unsigned instance and a signed
// instance share clock and reset; each task drives one scenario and checks
// its own results inline.
module tb_bin16_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        in_valid, in_ready, out_valid, out_ready, neg;
  logic [15:0] in_data;
  logic [19:0] bcd;
  logic [4:0]  digit_en;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_neg;
  logic [15:0] s_in_data;
  logic [19:0] s_bcd;
  logic [4:0]  s_digit_en;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bin16_to_bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED_IN(0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .bcd(bcd), .digit_en(digit_en), .neg(neg)
  );

  bin16_to_bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED_IN(1)) s_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .bcd(s_bcd), .digit_en(s_digit_en), .neg(s_neg)
  );

  // Reference by decimal division, independent of shift-add-3.
  function automatic logic [19:0] bcd_model(input int v);
    logic [19:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [4:0] en_model(input int v);
    logic [4:0] e;
    int p;
    e = 5'b00001;
    p = 10;
    for (int i = 1; i < 5; i++) begin
      e[i] = (v >= p);
      p = p * 10;
    end
    return e;
  endfunction

  // Drives one word into the selected instance (out_ready assumed high),
  // returns the result and the accept-to-out_valid edge count, and lets
  // the output handshake complete.
  task automatic run_conv(input logic sel, input logic [15:0] v,
                          output logic [19:0] b, output logic [4:0] e,
                          output logic n, output int lat);
    if (sel) begin s_in_data = v; s_in_valid = 1'b1; end
    else     begin in_data   = v; in_valid   = 1'b1; end
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    in_valid   = 1'b0;
    lat = 0;
    while (!(sel ? s_out_valid : out_valid) && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    b = sel ? s_bcd      : bcd;
    e = sel ? s_digit_en : digit_en;
    n = sel ? s_neg      : neg;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b1;
    #12;
    checks++;
    if ({in_ready, out_valid, bcd, digit_en, neg} !== 28'd0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b bcd=%h en=%b neg=%b, want all 0",
               in_ready, out_valid, bcd, digit_en, neg);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_max_unsigned();
    int lat;
    in_data = 16'd65535; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL accept_ready_drop: got in_ready=%b, want 0", in_ready);
    end
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat !== 16) begin
      errors++;
      $display("FAIL latency_65535: got %0d edges, want 16", lat);
    end
    checks++;
    if (bcd !== 20'h65535 || digit_en !== 5'b11111 || neg !== 1'b0) begin
      errors++;
      $display("FAIL conv_65535: got bcd=%h en=%b neg=%b, want 65535/11111/0", bcd, digit_en, neg);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL return_idle: got in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_values();
    logic [15:0] vin  [3] = '{16'd0, 16'd10000, 16'd9};
    logic [19:0] vbcd [3] = '{20'h00000, 20'h10000, 20'h00009};
    logic [4:0]  ven  [3] = '{5'b00001, 5'b11111, 5'b00001};
    logic [19:0] b; logic [4:0] e; logic n; int lat;
    for (int i = 0; i < 3; i++) begin
      run_conv(1'b0, vin[i], b, e, n, lat);
      checks++;
      if (b !== vbcd[i] || e !== ven[i] || lat !== 16) begin
        errors++;
        $display("FAIL value_%0d: got bcd=%h en=%b lat=%0d, want %h/%b/16",
                 vin[i], b, e, lat, vbcd[i], ven[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic stable;
    out_ready = 1'b0;
    in_data = 16'd4321; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    checks++;
    if (bcd !== 20'h04321 || digit_en !== 5'b01111 || lat !== 16) begin
      errors++;
      $display("FAIL bp_result: got bcd=%h en=%b lat=%0d, want 04321/01111/16", bcd, digit_en, lat);
    end
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_data  = 16'd999;
      @(posedge clk); #1;
      if (bcd !== 20'h04321 || digit_en !== 5'b01111 || out_valid !== 1'b1 || in_ready !== 1'b0)
        stable = 1'b0;
    end
    in_valid = 1'b0;
    checks++;
    if (stable !== 1'b1) begin
      errors++;
      $display("FAIL bp_hold: got bcd=%h en=%b vld=%b rdy=%b, want 04321/01111/1/0 throughout",
               bcd, digit_en, out_valid, in_ready);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got out_valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_signed();
    logic [15:0] vin  [3] = '{16'hFFFF, 16'h8000, 16'h7FFF};
    logic [19:0] vbcd [3] = '{20'h00001, 20'h32768, 20'h32767};
    logic        vneg [3] = '{1'b1, 1'b1, 1'b0};
    logic [4:0]  ven  [3] = '{5'b00001, 5'b11111, 5'b11111};
    logic [19:0] b; logic [4:0] e; logic n; int lat;
    for (int i = 0; i < 3; i++) begin
      run_conv(1'b1, vin[i], b, e, n, lat);
      checks++;
      if (b !== vbcd[i] || n !== vneg[i] || e !== ven[i]) begin
        errors++;
        $display("FAIL signed_%h: got bcd=%h neg=%b en=%b, want %h/%b/%b",
                 vin[i], b, n, e, vbcd[i], vneg[i], ven[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [19:0] b; logic [4:0] e; logic n; int lat;
    in_data = 16'd12345; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, bcd, digit_en, neg} !== 28'd0) begin
      errors++;
      $display("FAIL midreset_outputs: got rdy=%b vld=%b bcd=%h en=%b neg=%b, want all 0",
               in_ready, out_valid, bcd, digit_en, neg);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_conv(1'b0, 16'd777, b, e, n, lat);
    checks++;
    if (b !== 20'h00777 || e !== 5'b00111 || lat !== 16) begin
      errors++;
      $display("FAIL after_reset_777: got bcd=%h en=%b lat=%0d, want 00777/00111/16", b, e, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v;
    int prev, t, k;
    bit ok;
    out_ready = 1'b1;
    prev = -1;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      v = 16'($urandom_range(0, 65535));
      in_data = v;
      k = 0;
      while (!in_ready && k < 50) begin @(posedge clk); #1; k++; end
      @(posedge clk); #1;
      t = cyc;
      if (prev >= 0) begin
        checks++;
        if (t - prev !== 18) begin
          errors++;
          $display("FAIL b2b_spacing_%0d: got %0d cycles, want 18", i, t - prev);
        end
      end
      prev = t;
      k = 0;
      while (!out_valid && k < 50) begin @(posedge clk); #1; k++; end
      ok = (out_valid === 1'b1) && (bcd === bcd_model(int'(v))) &&
           (digit_en === en_model(int'(v))) && (neg === 1'b0);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL b2b_value_%0d: in=%0d got bcd=%h en=%b vld=%b, want %h/%b/1",
                 i, v, bcd, digit_en, out_valid, bcd_model(int'(v)), en_model(int'(v)));
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_max_unsigned();
    test_values();
    test_backpressure();
    test_signed();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bin16_to_bcd_seq.md
Name: bin16_to_bcd_seq

Overview:
- Sequential double-dabble binary-to-BCD converter, downstream of the trig/arith result stage.
- Takes a 16-bit result word (e.g. tan scaled by 10000) and produces packed BCD digits, a sign flag and leading-zero blanking enables for the display driver.
- One conversion at a time over a valid/ready handshake on both sides; WIDTH shift-add-3 iterations per conversion.

Parameters:
- WIDTH, 16: input word width in bits.
- DIGITS, 5: BCD digits produced; must be >= ceil(WIDTH*log10(2)) (5 for 16).
- SIGNED_IN, 0: 0 = in_data is unsigned; 1 = in_data is two's complement, converted as a magnitude with the sign reported on neg.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: in_data is valid.
- in_ready, output, 1: block can accept a word.
- in_data, input, WIDTH: binary value to convert.
- out_valid, output, 1: result outputs are valid.
- out_ready, input, 1: consumer takes the result.
- bcd, output, 4*DIGITS: packed BCD; digit 0 (units) in bits [3:0].
- digit_en, output, DIGITS: per-digit display enable (leading-zero blanking).
- neg, output, 1: value was negative (always 0 when SIGNED_IN=0).

Behaviour:
- Reset:
  - Asserting rst_n low forces state IDLE immediately, including mid-conversion; the in-flight word is discarded.
  - While in reset: in_ready=0, out_valid=0, bcd=0, digit_en=0, neg=0, iteration counter=0.
  - First cycle after release: in_ready=1.
- States: IDLE, CONVERT, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with in_valid=1, load the shift register:
    - magnitude = in_data, or -in_data when SIGNED_IN=1 and in_data[WIDTH-1]=1;
    - latch the sign into an internal flag;
    - clear the BCD accumulator and the counter;
    - go to CONVERT.
  - Magnitude is computed in WIDTH bits unsigned, so 0x8000 gives 32768.
- CONVERT:
  - in_ready=0, out_valid=0.
  - Each edge performs one step: every BCD digit >= 5 gets +3, then {bcd_acc, shift_reg} shifts left by one; counter increments.
  - The edge that completes step WIDTH goes to DONE. It registers bcd, neg and digit_en, and sets out_valid=1.
- Latency: out_valid is high exactly WIDTH edges after the accepting edge (16 for defaults).
- DONE:
  - out_valid=1, in_ready=0.
  - bcd, digit_en and neg are held stable until out_valid && out_ready at an edge, then go to IDLE.
  - Outputs keep their last value in IDLE; they are only meaningful while out_valid=1.
  - in_ready stays low during DONE, so there is no same-cycle accept; throughput is one word per WIDTH+2 cycles with out_ready held high.
- in_data and in_valid are ignored outside IDLE. in_valid may drop without consequence.
- digit_en:
  - digit_en[0] = 1 always.
  - digit_en[i] = 1 iff any of digits i..DIGITS-1 is nonzero.
  - Value 0 gives digit_en = 00001.
- neg = 1 only when SIGNED_IN=1 and the input was negative. A zero input never sets neg.
- Every BCD digit of bcd is always 0..9.

Test Plan:
- Reset, then in_data=16'd65535 (SIGNED_IN=0), out_ready=1 → in_ready drops next cycle; out_valid rises 16 edges after accept; bcd=20'h65535, digit_en=5'b11111, neg=0; in_ready=1 one cycle after the out handshake.
- in_data=0 → bcd=20'h00000, digit_en=5'b00001; in_data=16'd10000 → bcd=20'h10000, digit_en=5'b11111; in_data=16'd9 → bcd=20'h00009, digit_en=5'b00001.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid with in_data=16'd4321 → bcd=20'h04321, digit_en=5'b01111, stable throughout; in_valid pulses during DONE are ignored; raising out_ready completes and returns to IDLE.
- SIGNED_IN=1:
  - 16'hFFFF → neg=1, bcd=20'h00001;
  - 16'h8000 → neg=1, bcd=20'h32768;
  - 16'h7FFF → neg=0, bcd=20'h32767.
- Pull rst_n low at iteration 8 of converting 16'd12345 → outputs zero immediately; after release, convert 16'd777 → bcd=20'h00777, with no residue from the aborted word.
- Back-to-back random unsigned words with out_ready=1 against a reference model → every result matches; accept-to-accept spacing is 18 cycles.
